id_stage_ctrl: RTL and testbench

- Decode-stage sequencer between fetch and execute.
- Accepts instruction/PC pairs from fetch over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Classifies each instruction's format from its opcode and presents the instruction plus a registered format code to the immediate generator and execute stage.
- Handles back-pressure from execute and pipeline flush.

---
 rtl/id_stage_ctrl.sv | 146 ++++++++++++++
 tb/tb_id_stage_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: 2-entry skid buffer between fetch and execute,
// with registered opcode format classification and a saturating stall counter.
module id_stage_ctrl #(
  parameter int CNT_W = 16,
  parameter int XLEN  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             if_valid_i,
  input  logic [XLEN-1:0]  if_instr_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             if_ready_o,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [XLEN-1:0]  ex_instr_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [2:0]       ex_format_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_B = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  state_t state, state_next;

  logic [XLEN-1:0]  head_instr, head_pc, skid_instr, skid_pc;
  logic [2:0]       head_fmt, skid_fmt;
  logic             head_ill, skid_ill;
  logic [CNT_W-1:0] stall_cnt;

  logic       accept, consume;
  logic       load_head_in, load_head_skid, load_skid;
  logic [2:0] in_fmt;
  logic       in_ill;

  // Unknown opcodes are tagged R so the immediate generator sees a harmless format.
  always_comb begin
    in_fmt = FMT_R;
    in_ill = 1'b0;
    case (if_instr_i[6:0])
      7'b0110011:                         in_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: in_fmt = FMT_I;
      7'b0100011:                         in_fmt = FMT_S;
      7'b0110111, 7'b0010111:             in_fmt = FMT_U;
      7'b1100011:                         in_fmt = FMT_B;
      7'b1101111:                         in_fmt = FMT_J;
      default:                            in_ill = 1'b1;
    endcase
  end

  assign if_ready_o = (state != TWO);
  assign ex_valid_o = (state != EMPTY);
  assign accept     = if_valid_i & if_ready_o;
  assign consume    = ex_valid_o & ex_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= EMPTY;
    else         state <= state_next;
  end

  // Flush overrides everything; a same-cycle accept is simply never loaded.
  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
        ONE: begin
          if (accept && consume) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        TWO: if (consume) begin
          state_next     = ONE;
          load_head_skid = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_instr <= '0;
      head_pc    <= '0;
      head_fmt   <= FMT_R;
      head_ill   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_fmt   <= FMT_R;
      skid_ill   <= 1'b0;
    end else begin
      if (load_head_in) begin
        head_instr <= if_instr_i;
        head_pc    <= if_pc_i;
        head_fmt   <= in_fmt;
        head_ill   <= in_ill;
      end else if (load_head_skid) begin
        head_instr <= skid_instr;
        head_pc    <= skid_pc;
        head_fmt   <= skid_fmt;
        head_ill   <= skid_ill;
      end
      if (load_skid) begin
        skid_instr <= if_instr_i;
        skid_pc    <= if_pc_i;
        skid_fmt   <= in_fmt;
        skid_ill   <= in_ill;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_cnt <= '0;
    else if (ex_valid_o && !ex_ready_i && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign ex_instr_o   = head_instr;
  assign ex_pc_o      = head_pc;
  assign ex_format_o  = head_fmt;
  assign ex_illegal_o = head_ill;
  assign stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: table-driven stream with a FIFO scoreboard, plus
// hand sequences for back-pressure, flush, counter saturation and async reset.
module tb_id_stage_ctrl;
  localparam int CNT_W = 4;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             if_valid_i;
  logic [XLEN-1:0]  if_instr_i;
  logic [XLEN-1:0]  if_pc_i;
  logic             if_ready_o;
  logic             ex_valid_o;
  logic             ex_ready_i;
  logic [XLEN-1:0]  ex_instr_o;
  logic [XLEN-1:0]  ex_pc_o;
  logic [2:0]       ex_format_o;
  logic             ex_illegal_o;
  logic [CNT_W-1:0] stall_cnt_o;

  id_stage_ctrl #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .if_ready_o(if_ready_o), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_instr_o(ex_instr_o), .ex_pc_o(ex_pc_o), .ex_format_o(ex_format_o),
    .ex_illegal_o(ex_illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[12];
  vec_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [2:0] fmt, input logic ill);
    cur.instr = instr; cur.pc = pc; cur.fmt = fmt; cur.ill = ill;
    if_instr_i = instr;
    if_pc_i    = pc;
  endtask

  // Called at posedge+1: check handshake against the model, retire/push, then advance.
  task automatic cycle();
    vec_t e;
    int   n;
    n = sb.size();
    chk("ex_valid", {31'd0, ex_valid_o}, {31'd0, n != 0});
    chk("if_ready", {31'd0, if_ready_o}, {31'd0, n < 2});
    if (n != 0 && ex_ready_i) begin
      e = sb.pop_front();
      chk("ex_instr", ex_instr_o, e.instr);
      chk("ex_pc", ex_pc_o, e.pc);
      chk("ex_format", {29'd0, ex_format_o}, {29'd0, e.fmt});
      chk("ex_illegal", {31'd0, ex_illegal_o}, {31'd0, e.ill});
      $display("xfer pc=%h instr=%h fmt=%0d ill=%0b", ex_pc_o, ex_instr_o, ex_format_o, ex_illegal_o);
    end
    if (flush_i) sb.delete();
    else if (if_valid_i && n < 2) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; ex_ready_i = 1'b0;
    present(32'h0, 32'h0, 3'd0, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    int i, budget;
    logic acc;
    tbl[0]  = '{32'h00500093, 32'h0, 3'd1, 1'b0};
    tbl[1]  = '{32'h00112023, 32'h0, 3'd2, 1'b0};
    tbl[2]  = '{32'h123450B7, 32'h0, 3'd3, 1'b0};
    tbl[3]  = '{32'h002081B3, 32'h0, 3'd0, 1'b0};
    tbl[4]  = '{32'h0000007F, 32'h0, 3'd0, 1'b1};
    tbl[5]  = '{32'h00000063, 32'h0, 3'd4, 1'b0};
    tbl[6]  = '{32'h0000006F, 32'h0, 3'd5, 1'b0};
    tbl[7]  = '{32'h00002083, 32'h0, 3'd1, 1'b0};
    tbl[8]  = '{32'h00008067, 32'h0, 3'd1, 1'b0};
    tbl[9]  = '{32'h00000097, 32'h0, 3'd3, 1'b0};
    tbl[10] = '{32'h00000001, 32'h0, 3'd0, 1'b1};
    tbl[11] = '{32'h40208033, 32'h0, 3'd0, 1'b0};
    for (int k = 0; k < 12; k++) tbl[k].pc = 32'h100 + 32'(4 * k);

    // Reset values
    do_reset();
    chk("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready_o}, 32'd1);
    chk("rst_ex_instr", ex_instr_o, 32'd0);
    chk("rst_ex_pc", ex_pc_o, 32'd0);
    chk("rst_ex_format", {29'd0, ex_format_o}, 32'd0);
    chk("rst_ex_illegal", {31'd0, ex_illegal_o}, 32'd0);
    chk("rst_stall", {28'd0, stall_cnt_o}, 32'd0);

    // ADDI with execute ready: visible one cycle later
    ex_ready_i = 1'b1; if_valid_i = 1'b1;
    present(32'h00500093, 32'h0, 3'd1, 1'b0);
    cycle();
    if_valid_i = 1'b0;
    chk("addi_valid", {31'd0, ex_valid_o}, 32'd1);
    chk("addi_format", {29'd0, ex_format_o}, 32'd1);
    chk("addi_pc", ex_pc_o, 32'd0);
    chk("addi_illegal", {31'd0, ex_illegal_o}, 32'd0);
    cycle();
    cycle();

    // Back-pressure: SW at head, LUI in skid, ADD refused
    do_reset();
    if_valid_i = 1'b1;
    present(32'h00112023, 32'h4, 3'd2, 1'b0); cycle();
    present(32'h123450B7, 32'h8, 3'd3, 1'b0); cycle();
    present(32'h002081B3, 32'hC, 3'd0, 1'b0); cycle(); cycle();
    chk("bp_head_instr", ex_instr_o, 32'h00112023);
    chk("bp_head_format", {29'd0, ex_format_o}, 32'd2);
    chk("bp_if_ready", {31'd0, if_ready_o}, 32'd0);
    chk("bp_stall", {28'd0, stall_cnt_o}, 32'd3);
    ex_ready_i = 1'b1;
    cycle();
    chk("bp_lui_instr", ex_instr_o, 32'h123450B7);
    chk("bp_lui_format", {29'd0, ex_format_o}, 32'd3);
    cycle();
    if_valid_i = 1'b0;
    chk("bp_add_instr", ex_instr_o, 32'h002081B3);
    chk("bp_add_format", {29'd0, ex_format_o}, 32'd0);
    cycle();
    chk("bp_stall_after", {28'd0, stall_cnt_o}, 32'd3);
    cycle();

    // Table-driven stream with random back-pressure
    do_reset();
    i = 0; budget = 0;
    while (i < 12 && budget < 300) begin
      if_valid_i = 1'b1;
      present(tbl[i].instr, tbl[i].pc, tbl[i].fmt, tbl[i].ill);
      ex_ready_i = ($urandom_range(0, 3) != 0);
      acc = (sb.size() < 2);
      cycle();
      if (acc) i++;
      budget++;
    end
    chk("stream_all_accepted", i, 12);
    if_valid_i = 1'b0; ex_ready_i = 1'b1;
    while (sb.size() != 0 && budget < 400) begin
      cycle();
      budget++;
    end
    chk("stream_drained", sb.size(), 0);
    cycle();

    // Flush in TWO with a new instruction presented
    do_reset();
    if_valid_i = 1'b1;
    present(32'h00000063, 32'h20, 3'd4, 1'b0); cycle();
    present(32'h0000006F, 32'h24, 3'd5, 1'b0); cycle();
    chk("fl_full", {31'd0, if_ready_o}, 32'd0);
    ex_ready_i = 1'b1; if_valid_i = 1'b0; cycle();
    ex_ready_i = 1'b0; if_valid_i = 1'b1;
    present(32'h00000093, 32'h28, 3'd1, 1'b0); cycle();
    present(32'h00000013, 32'h2C, 3'd1, 1'b0); cycle();
    flush_i = 1'b1;
    present(32'h00100113, 32'h30, 3'd1, 1'b0);
    cycle();
    flush_i = 1'b0; if_valid_i = 1'b0;
    chk("fl_ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("fl_if_ready", {31'd0, if_ready_o}, 32'd1);
    ex_ready_i = 1'b1;
    repeat (3) cycle();

    // Saturation, flush keeps count, async reset clears it mid-stream
    do_reset();
    if_valid_i = 1'b1;
    present(32'h00500093, 32'h40, 3'd1, 1'b0); cycle();
    if_valid_i = 1'b0;
    repeat (20) cycle();
    chk("sat_stall", {28'd0, stall_cnt_o}, 32'd15);
    flush_i = 1'b1; cycle(); flush_i = 1'b0;
    chk("sat_after_flush", {28'd0, stall_cnt_o}, 32'd15);
    if_valid_i = 1'b1;
    present(32'h00112023, 32'h44, 3'd2, 1'b0); cycle();
    present(32'h123450B7, 32'h48, 3'd3, 1'b0); cycle();
    if_valid_i = 1'b0;
    chk("ar_in_two", {31'd0, if_ready_o}, 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("ar_stall", {28'd0, stall_cnt_o}, 32'd0);
    chk("ar_ex_instr", ex_instr_o, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    chk("ar_if_ready", {31'd0, if_ready_o}, 32'd1);
    ex_ready_i = 1'b1;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
